// File: rtl/crc22_check.sv
// Receive-side CRC-22 (x^22 + x + 1) checker for 16-bit readout packets.
// The two trailing words carry the CRC; a two-word delay keeps them out of the sum.
//   state | meaning
//   IDLE  | waiting for a start-of-packet word
//   PKT   | accumulating data words of a packet
//   CHK   | one-cycle result strobe; input handled as in IDLE
module crc22_check #(
  parameter int MXWDS  = 12,
  parameter int MXSTAT = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [15:0]       din,
  input  logic              din_valid,
  input  logic              din_sop,
  input  logic              din_eop,
  input  logic              stat_clr,
  output logic              crc_done,
  output logic              crc_match,
  output logic              crc_err,
  output logic              frame_err,
  output logic [21:0]       crc_calc,
  output logic [21:0]       crc_rx,
  output logic [MXWDS-1:0]  wd_count,
  output logic [MXSTAT-1:0] pkt_count,
  output logic [MXSTAT-1:0] err_count,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_PKT, S_CHK} state_t;

  state_t            state_q, state_d;
  logic [21:0]       acc_q, acc_d;
  logic [15:0]       h1_q, h1_d, h2_q, h2_d;
  logic              h1v_q, h1v_d, h2v_q, h2v_d;
  logic [MXWDS-1:0]  wd_q, wd_d, wd_inc;
  logic [21:0]       calc_q, calc_d, rx_q, rx_d, folded, rx_now;
  logic [MXWDS-1:0]  wdc_q, wdc_d;
  logic              match_q, match_d, err_q, err_d;
  logic              ferr_q, ferr_d;
  logic [MXSTAT-1:0] pkt_q, pkt_d, errc_q, errc_d;
  logic [1:0]        err_inc;
  logic [MXSTAT:0]   pkt_sum, err_sum;

  function automatic logic [21:0] crc_step(input logic [21:0] c, input logic [15:0] d);
    logic [21:0] n;
    n[0] = d[0] ^ c[6];
    for (int i = 1; i < 16; i++) n[i] = d[i] ^ d[i-1] ^ c[i+6] ^ c[i+5];
    n[16]    = d[15] ^ c[0] ^ c[21];
    n[21:17] = c[5:1];
    return n;
  endfunction

  assign folded = h2v_q ? crc_step(acc_q, h2_q) : acc_q;
  assign rx_now = {din[10:0], h1_q[10:0]};
  assign wd_inc = (&wd_q) ? wd_q : wd_q + MXWDS'(1);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    h1_d    = h1_q;
    h1v_d   = h1v_q;
    h2_d    = h2_q;
    h2v_d   = h2v_q;
    wd_d    = wd_q;
    calc_d  = calc_q;
    rx_d    = rx_q;
    wdc_d   = wdc_q;
    match_d = match_q;
    err_d   = err_q;
    ferr_d  = 1'b0;
    case (state_q)
      S_PKT: begin
        if (din_valid && din_sop) begin
          // Restart on the new sop; a sop that is also eop is a runt and drops to IDLE.
          ferr_d = 1'b1;
          if (din_eop) begin
            state_d = S_IDLE;
            h1v_d   = 1'b0;
            h2v_d   = 1'b0;
          end else begin
            acc_d = '0;
            h1_d  = din;
            h1v_d = 1'b1;
            h2v_d = 1'b0;
            wd_d  = MXWDS'(1);
          end
        end else if (din_valid && din_eop) begin
          calc_d  = folded;
          rx_d    = rx_now;
          wdc_d   = wd_inc;
          match_d = (rx_now == folded);
          err_d   = (rx_now != folded);
          h1v_d   = 1'b0;
          h2v_d   = 1'b0;
          state_d = S_CHK;
        end else if (din_valid) begin
          acc_d = folded;
          h2_d  = h1_q;
          h2v_d = h1v_q;
          h1_d  = din;
          h1v_d = 1'b1;
          wd_d  = wd_inc;
        end
      end
      default: begin
        state_d = S_IDLE;
        if (din_valid && din_sop && !din_eop) begin
          state_d = S_PKT;
          acc_d   = '0;
          h1_d    = din;
          h1v_d   = 1'b1;
          h2v_d   = 1'b0;
          wd_d    = MXWDS'(1);
        end else if (din_valid && din_eop) begin
          ferr_d = 1'b1;
        end
      end
    endcase
  end

  // Frame and CRC errors can land in the same cycle when a CHK cycle sees a stray eop.
  always_comb begin
    err_inc = 2'(ferr_d) + 2'(state_q == S_CHK && err_q);
    err_sum = {1'b0, errc_q} + (MXSTAT+1)'(err_inc);
    pkt_sum = {1'b0, pkt_q} + (MXSTAT+1)'(state_q == S_CHK);
    pkt_d   = pkt_sum[MXSTAT] ? '1 : pkt_sum[MXSTAT-1:0];
    errc_d  = err_sum[MXSTAT] ? '1 : err_sum[MXSTAT-1:0];
    if (stat_clr) begin
      pkt_d  = '0;
      errc_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      h1_q    <= '0;
      h1v_q   <= 1'b0;
      h2_q    <= '0;
      h2v_q   <= 1'b0;
      wd_q    <= '0;
      calc_q  <= '0;
      rx_q    <= '0;
      wdc_q   <= '0;
      match_q <= 1'b0;
      err_q   <= 1'b0;
      ferr_q  <= 1'b0;
      pkt_q   <= '0;
      errc_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      h1_q    <= h1_d;
      h1v_q   <= h1v_d;
      h2_q    <= h2_d;
      h2v_q   <= h2v_d;
      wd_q    <= wd_d;
      calc_q  <= calc_d;
      rx_q    <= rx_d;
      wdc_q   <= wdc_d;
      match_q <= match_d;
      err_q   <= err_d;
      ferr_q  <= ferr_d;
      pkt_q   <= pkt_d;
      errc_q  <= errc_d;
    end
  end

  assign crc_done  = (state_q == S_CHK);
  assign busy      = (state_q != S_IDLE);
  assign crc_match = match_q;
  assign crc_err   = err_q;
  assign frame_err = ferr_q;
  assign crc_calc  = calc_q;
  assign crc_rx    = rx_q;
  assign wd_count  = wdc_q;
  assign pkt_count = pkt_q;
  assign err_count = errc_q;

endmodule

// File: tb/tb_crc22_check.sv
// Directed bench for crc22_check: driver queues expected results, a negedge monitor checks them.
module tb_crc22_check;
  localparam int MXWDS  = 3;
  localparam int MXSTAT = 4;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic [15:0]       din = '0;
  logic              din_valid = 1'b0, din_sop = 1'b0, din_eop = 1'b0, stat_clr = 1'b0;
  logic              crc_done, crc_match, crc_err, frame_err, busy;
  logic [21:0]       crc_calc, crc_rx;
  logic [MXWDS-1:0]  wd_count;
  logic [MXSTAT-1:0] pkt_count, err_count;

  crc22_check #(.MXWDS(MXWDS), .MXSTAT(MXSTAT)) dut (
    .clock(clock), .reset_n(reset_n), .din(din), .din_valid(din_valid),
    .din_sop(din_sop), .din_eop(din_eop), .stat_clr(stat_clr),
    .crc_done(crc_done), .crc_match(crc_match), .crc_err(crc_err),
    .frame_err(frame_err), .crc_calc(crc_calc), .crc_rx(crc_rx),
    .wd_count(wd_count), .pkt_count(pkt_count), .err_count(err_count), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          is_frame;
    logic        match;
    logic [21:0] calc;
    logic [21:0] rx;
    logic [2:0]  wd;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   exp_pkt = 0;
  int   exp_err = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
    end
  endtask

  always @(negedge clock) begin
    if (reset_n && (crc_done || frame_err)) begin
      if (sb.size() == 0) begin
        chk("unexpected_event", {30'd0, crc_done, frame_err}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("event_cycle", cyc, e.cyc);
        chk("frame_err", {31'd0, frame_err}, {31'd0, e.is_frame});
        chk("crc_done", {31'd0, crc_done}, {31'd0, !e.is_frame});
        if (!e.is_frame) begin
          chk("crc_match", {31'd0, crc_match}, {31'd0, e.match});
          chk("crc_err", {31'd0, crc_err}, {31'd0, !e.match});
          chk("crc_calc", {10'd0, crc_calc}, {10'd0, e.calc});
          chk("crc_rx", {10'd0, crc_rx}, {10'd0, e.rx});
          chk("wd_count", {29'd0, wd_count}, {29'd0, e.wd});
        end
      end
    end
  end

  task automatic send(input logic [15:0] d, input bit sop, input bit eop);
    din = d; din_valid = 1'b1; din_sop = sop; din_eop = eop;
    @(posedge clock); #1;
    din_valid = 1'b0; din_sop = 1'b0; din_eop = 1'b0; din = 16'hdead;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic bump_err();
    if (exp_err < 15) exp_err++;
  endtask

  task automatic expect_done(input logic m, input logic [21:0] c, input logic [21:0] r, input logic [2:0] w);
    exp_t e;
    e.is_frame = 1'b0; e.match = m; e.calc = c; e.rx = r; e.wd = w; e.cyc = cyc;
    sb.push_back(e);
    if (exp_pkt < 15) exp_pkt++;
    if (!m) bump_err();
  endtask

  task automatic expect_frame();
    exp_t e;
    e.is_frame = 1'b1; e.match = 1'b0; e.calc = '0; e.rx = '0; e.wd = '0; e.cyc = cyc;
    sb.push_back(e);
    bump_err();
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, "_pkt_count"}, {28'd0, pkt_count}, exp_pkt);
    chk({tag, "_err_count"}, {28'd0, err_count}, exp_err);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_outs"}, {26'd0, crc_done, crc_match, crc_err, frame_err, busy, 1'b0}, 32'd0);
    chk({tag, "_calc"}, {10'd0, crc_calc}, 32'd0);
    chk({tag, "_rx"}, {10'd0, crc_rx}, 32'd0);
    chk({tag, "_wd"}, {29'd0, wd_count}, 32'd0);
    chk({tag, "_pkt"}, {28'd0, pkt_count}, 32'd0);
    chk({tag, "_err"}, {28'd0, err_count}, 32'd0);
  endtask

  initial begin
    #3 chk_all_zero("reset");
    #20 reset_n = 1'b1;
    idle(2);

    // Basic 3-word packet: data 0x0001
    send(16'h0001, 1, 0);
    chk("busy_in_pkt", {31'd0, busy}, 32'd1);
    send(16'h0003, 0, 0);
    send(16'h0000, 0, 1); expect_done(1, 22'h000003, 22'h000003, 3'd3);
    idle(3);
    chk_counters("pkt1");
    chk("held_match", {31'd0, crc_match}, 32'd1);
    chk("busy_idle", {31'd0, busy}, 32'd0);

    // Back-to-back: good then bad high word, sop during CHK
    send(16'h8000, 1, 0);
    send(16'h0000, 0, 0);
    send(16'h0030, 0, 1); expect_done(1, 22'h018000, 22'h018000, 3'd3);
    send(16'h8000, 1, 0);
    send(16'h0000, 0, 0);
    send(16'h0031, 0, 1); expect_done(0, 22'h018000, 22'h018800, 3'd3);
    idle(3);
    chk_counters("bad_hi");
    chk("held_err", {31'd0, crc_err}, 32'd1);

    // Two data words with gaps
    send(16'h0001, 1, 0); idle(2);
    send(16'h0000, 0, 0); idle(1);
    send(16'h0000, 0, 0); idle(3);
    send(16'h0060, 0, 1); expect_done(1, 22'h030000, 22'h030000, 3'd4);
    idle(3);

    // Minimum packet, then runt sop&eop; upper bits of CRC words ignored
    send(16'hf800, 1, 0);
    send(16'hf800, 0, 1); expect_done(1, 22'h0, 22'h0, 3'd2);
    send(16'h1234, 1, 1); expect_frame();
    idle(3);
    chk_counters("runt");

    // sop mid-packet restarts
    send(16'h1234, 1, 0);
    send(16'h5555, 0, 0);
    send(16'h0001, 1, 0); expect_frame();
    send(16'h0003, 0, 0);
    send(16'h0000, 0, 1); expect_done(1, 22'h000003, 22'h000003, 3'd3);
    idle(3);
    chk_counters("restart");

    // Async reset mid-packet
    send(16'h0001, 1, 0);
    send(16'h0002, 0, 0);
    #2 reset_n = 1'b0;
    #1 chk_all_zero("midreset");
    exp_pkt = 0; exp_err = 0;
    #3 reset_n = 1'b1;
    idle(2);
    send(16'h8000, 1, 0);
    send(16'h0000, 0, 0);
    send(16'h0030, 0, 1); expect_done(1, 22'h018000, 22'h018000, 3'd3);
    idle(3);
    chk_counters("post_reset");

    // Word counter saturates, check still made
    send(16'h0000, 1, 0);
    for (int i = 0; i < 9; i++) send(16'h0000, 0, 0);
    send(16'h0000, 0, 1); expect_done(1, 22'h0, 22'h0, 3'd7);
    idle(3);

    // Stray eop in IDLE and error counter saturation
    send(16'h0000, 0, 1); expect_frame();
    send(16'h0000, 0, 0);
    idle(2);
    chk_counters("stray_eop");
    for (int i = 0; i < 20; i++) begin send(16'h0000, 0, 1); expect_frame(); end
    idle(3);
    chk_counters("err_sat");

    // stat_clr wins over a simultaneous error
    stat_clr = 1'b1;
    send(16'h0000, 0, 1); expect_frame();
    stat_clr = 1'b0;
    exp_pkt = 0; exp_err = 0;
    idle(3);
    chk_counters("stat_clr");

    idle(2);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
